mul_div_sequencer: RTL and testbench
====================================

MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

Interface
REQ-001 Parameter WORD_LENGTH, default `WORD_LENGTH (32), operand/result width.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 op  in  2  00 MUL low word, 01 MUL high word, 10 DIV quotient, 11 DIV remainder.
REQ-006 a_in, b_in  in  WORD_LENGTH  multiplicand/dividend, multiplier/divisor; captured with start.
REQ-007 abort  in  1  synchronous cancel of a running operation.
REQ-008 busy  out  1  high in any state other than IDLE.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 result  out  WORD_LENGTH  held from done until the next accepted start.
REQ-011 err  out  1  divide-by-zero flag, valid with done.
REQ-012 alu_a, alu_b  out  WORD_LENGTH, alu_ac  out  8  drive the shared AluUnit.
REQ-013 alu_r  in  WORD_LENGTH, alu_c  in  1  AluUnit result and carry.

Function
REQ-014 States IDLE, CALC, DONE; IDLE->CALC on start; IDLE->DONE on start with DIV/REM and b_in==0.
REQ-015 CALC SHALL run exactly WORD_LENGTH cycles, counted by an iteration counter loaded with WORD_LENGTH-1 and decremented to 0; CALC->DONE when the counter is 0.
REQ-016 DONE SHALL last one cycle with done=1, then return to IDLE; latency start edge -> done = WORD_LENGTH+1 cycles (1 cycle for divide-by-zero).
REQ-017 MUL: per cycle alu_a=high partial, alu_b=multiplicand when multiplier LSB=1 else 0, alu_ac=AC_ADD; {alu_c, alu_r, low partial} shifted right one bit.
REQ-018 DIV: restoring; per cycle alu_a=remainder shifted left with next dividend bit, alu_b=divisor, alu_ac=AC_SUB; alu_c=1 (no borrow) keeps alu_r and shifts in quotient 1, else restores and shifts in 0.
REQ-019 Divide-by-zero: err=1, result all ones, no CALC cycles.
REQ-020 start while busy (including DONE) SHALL be ignored without side effects.
REQ-021 abort in CALC SHALL return to IDLE next edge, no done, result unchanged; abort in IDLE/DONE ignored.
REQ-022 Simultaneous start and abort in IDLE: start wins.
REQ-023 In IDLE and DONE alu_ac=AC_ADD, alu_a=alu_b=0.
REQ-024 err cleared on every accepted start.

Reset
REQ-025 rst_n low SHALL force IDLE immediately, including mid-operation: busy=0, done=0, err=0, result=0, counter=0, alu outputs 0 with alu_ac=AC_ADD.
REQ-026 First start accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro MULDIV_SIGNED_EN: when defined, input port sgn (1 bit, captured with start) selects two's-complement operation; operands converted to magnitudes at start, one extra FIX state between CALC and DONE negates the result (quotient sign = sign a XOR sign b, remainder sign = sign a); latency WORD_LENGTH+2.
REQ-028 Without MULDIV_SIGNED_EN: no sgn port, no FIX state, unsigned only.

Structure
REQ-029 Shared package (VCPU32.v) SHALL hold WORD_LENGTH, AC_ADD, AC_SUB, op encodings and state encodings.
REQ-030 No sub-module; the AluUnit instance lives in the parent and is wired to alu_* ports.

Verification
REQ-031 MUL 7 x 6 -> result 0x0000002A, err 0, done exactly 33 cycles after start, busy high 32 cycles before done.
REQ-032 MULH 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-033 DIV 100 / 7 -> 0x0000000E; REM 100 / 7 -> 0x00000002; DIV 5 / 9 -> 0, REM -> 5.
REQ-034 DIV 0x1234 / 0 -> err 1, result 0xFFFFFFFF, done 1 cycle after start.
REQ-035 start during CALC cycle 10 -> ignored, original result delivered; abort in cycle 10 -> IDLE next cycle, no done pulse.
REQ-036 rst_n low in CALC cycle 20 -> busy 0 asynchronously, result 0; new MUL 3 x 3 after release -> 9.

Source files
------------

// File: rtl/mul_div_sequencer_pkg.sv
// Shared constants for the multiply/divide sequencer: word length, ALU opcodes,
// operation encodings and FSM state encodings.
package mul_div_sequencer_pkg;

`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

  localparam int WORD_LENGTH = `WORD_LENGTH;

  localparam logic [7:0] AC_ADD = 8'h00;
  localparam logic [7:0] AC_SUB = 8'h01;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/mul_div_sequencer.sv
// Multi-cycle shift-add multiplier / restoring divider that borrows an external shared ALU.
// Defining MULDIV_SIGNED_EN adds the sgn port and a sign-fixup state for two's-complement operands.
module mul_div_sequencer #(
  parameter int WORD_LENGTH = mul_div_sequencer_pkg::WORD_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             op,
`ifdef MULDIV_SIGNED_EN
  input  logic                   sgn,
`endif
  input  logic [WORD_LENGTH-1:0] a_in,
  input  logic [WORD_LENGTH-1:0] b_in,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [WORD_LENGTH-1:0] result,
  output logic                   err,
  output logic [WORD_LENGTH-1:0] alu_a,
  output logic [WORD_LENGTH-1:0] alu_b,
  output logic [7:0]             alu_ac,
  input  logic [WORD_LENGTH-1:0] alu_r,
  input  logic                   alu_c
);
  import mul_div_sequencer_pkg::*;

  localparam int            CW       = $clog2(WORD_LENGTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WORD_LENGTH - 1);

  state_e                 state_q;
  op_e                    op_q;
  logic [CW-1:0]          cnt_q;
  logic [WORD_LENGTH-1:0] hi_q, lo_q, opnd_q, result_q;
  logic                   busy_q, done_q, err_q;

  logic [WORD_LENGTH-1:0] hi_d, lo_d, rem_shift, a_op, b_op;
  logic                   div_keep, div_zero;

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign err      = err_q;
  assign div_zero = op[1] & (b_in == '0);

`ifdef MULDIV_SIGNED_EN
  logic                     neg_q, neg_d, a_neg, b_neg;
  logic [2*WORD_LENGTH-1:0] prod_fix;
  logic [WORD_LENGTH-1:0]   word_fix, fix_result;

  // Operands become magnitudes at start; the sign is reapplied to the finished result in FIX.
  always_comb begin
    a_neg    = sgn & a_in[WORD_LENGTH-1];
    b_neg    = sgn & b_in[WORD_LENGTH-1];
    a_op     = a_neg ? -a_in : a_in;
    b_op     = b_neg ? -b_in : b_in;
    neg_d    = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    word_fix = op_q[0] ? hi_q : lo_q;
    if (neg_q) word_fix = -word_fix;
    fix_result = op_q[1] ? word_fix
               : (op_q[0] ? prod_fix[2*WORD_LENGTH-1:WORD_LENGTH] : prod_fix[WORD_LENGTH-1:0]);
  end
`else
  assign a_op = a_in;
  assign b_op = b_in;
`endif

  // hi holds the partial product / partial remainder, lo the multiplier / dividend-then-quotient.
  assign rem_shift = {hi_q[WORD_LENGTH-2:0], lo_q[WORD_LENGTH-1]};
  // A remainder bit shifted out of hi means the true value exceeds any divisor.
  assign div_keep  = alu_c | hi_q[WORD_LENGTH-1];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (op_q[1]) begin
      if (div_keep) begin
        hi_d = alu_r;
        lo_d = {lo_q[WORD_LENGTH-2:0], 1'b1};
      end else begin
        hi_d = rem_shift;
        lo_d = {lo_q[WORD_LENGTH-2:0], 1'b0};
      end
    end else begin
      hi_d = {alu_c, alu_r[WORD_LENGTH-1:1]};
      lo_d = {alu_r[0], lo_q[WORD_LENGTH-1:1]};
    end
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_ac = AC_ADD;
    if (state_q == ST_CALC) begin
      if (op_q[1]) begin
        alu_a  = rem_shift;
        alu_b  = opnd_q;
        alu_ac = AC_SUB;
      end else begin
        alu_a = hi_q;
        alu_b = lo_q[0] ? opnd_q : '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, and the async reset clears
  // every register, the datapath words included, so no X can reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q   <= op_e'(op);
            busy_q <= 1'b1;
            err_q  <= div_zero;
            hi_q   <= '0;
            lo_q   <= op[1] ? a_op : b_op;
            opnd_q <= op[1] ? b_op : a_op;
`ifdef MULDIV_SIGNED_EN
            neg_q  <= neg_d;
`endif
            if (div_zero) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              result_q <= '1;
            end else begin
              state_q <= ST_CALC;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        ST_CALC: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            if (cnt_q == '0) begin
`ifdef MULDIV_SIGNED_EN
              state_q  <= ST_FIX;
`else
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              result_q <= op_q[0] ? hi_d : lo_d;
`endif
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
`ifdef MULDIV_SIGNED_EN
        ST_FIX: begin
          state_q  <= ST_DONE;
          done_q   <= 1'b1;
          result_q <= fix_result;
        end
`endif
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Self-checking bench for mul_div_sequencer: models the shared ALU, keeps a timeline-level
// reference of busy/done/result/err, and runs directed vectors with literal expectations.
module tb_mul_div_sequencer;
  import mul_div_sequencer_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, start, abort, busy, done, err, alu_c;
  logic [1:0]   op;
  logic [W-1:0] a_in, b_in, result, alu_a, alu_b, alu_r;
  logic [7:0]   alu_ac;

  int n_checks = 0;
  int n_errors = 0;

  mul_div_sequencer #(.WORD_LENGTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .abort(abort), .busy(busy), .done(done), .result(result), .err(err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ac(alu_ac), .alu_r(alu_r), .alu_c(alu_c)
  );

  always #5 clk = ~clk;

  // Shared ALU: add with carry out, subtract with carry = no borrow.
  always_comb begin
    {alu_c, alu_r} = '0;
    if (alu_ac == AC_ADD)      {alu_c, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
    else if (alu_ac == AC_SUB) {alu_c, alu_r} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a, b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (o)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (b == 0) ? '1 : a / b;
      default: return (b == 0) ? '1 : a % b;
    endcase
  endfunction

  // Reference timeline: an accepted op completes W edges later (same edge for divide by zero),
  // stays busy through the done cycle, and can be cancelled by abort before completion.
  int           cyc = 0;
  int           done_at = -10;
  logic         m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, pend_err = 1'b0;
  logic [1:0]   m_op = 2'b00;
  logic [W-1:0] m_result = '0, pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_result = '0; done_at = -10;
    end else begin
      cyc++;
      m_done = 1'b0;
      if (m_busy) begin
        if (cyc == done_at + 1) m_busy = 1'b0;
        else if (abort) begin m_busy = 1'b0; done_at = -10; end
      end else if (start) begin
        m_busy   = 1'b1;
        m_err    = 1'b0;
        m_op     = op;
        pend     = ref_result(op, a_in, b_in);
        pend_err = op[1] && (b_in == 0);
        done_at  = cyc + (pend_err ? 0 : W);
      end
      if (m_busy && cyc == done_at) begin
        m_done = 1'b1; m_result = pend; m_err = pend_err;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp busy", busy, m_busy);
      check("cmp done", done, m_done);
      check("cmp err", err, m_err);
      check("cmp result", result, m_result);
      if (!m_busy || m_done) begin
        check("cmp alu_a idle", alu_a, 0);
        check("cmp alu_b idle", alu_b, 0);
        check("cmp alu_ac idle", alu_ac, AC_ADD);
      end else begin
        check("cmp alu_ac calc", alu_ac, m_op[1] ? AC_SUB : AC_ADD);
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] a, b,
                       input logic with_abort, input int inject_at, input logic poke_done,
                       input logic [W-1:0] exp_res, input logic exp_err, input int exp_lat);
    int n, busy_n;
    start = 1'b1; op = o; a_in = a; b_in = b; abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; a_in = 32'hDEAD_BEEF; b_in = 32'h0BAD_F00D;
    n = 1; busy_n = 0;
    while (!done && n < 200) begin
      busy_n += int'(busy);
      if (n == inject_at) begin
        start = 1'b1; op = 2'b10; a_in = 32'd99; b_in = '0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({name, " latency"}, n, exp_lat);
    check({name, " busy cycles"}, busy_n, exp_lat - 1);
    check({name, " result"}, result, exp_res);
    check({name, " err"}, err, exp_err);
    if (poke_done) begin
      start = 1'b1; op = 2'b00; a_in = 32'd2; b_in = 32'd2;
      @(posedge clk); #1;
      start = 1'b0;
      check({name, " start in done busy"}, busy, 0);
      check({name, " start in done result"}, result, exp_res);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = 2'b00; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset result", result, 0);
    check("reset alu_a", alu_a, 0);
    check("reset alu_ac", alu_ac, AC_ADD);
    rst_n = 1'b1;

    do_op("mul 7x6",      2'b00, 32'd7,        32'd6,        0, -1, 0, 32'h0000_002A, 0, 33);
    do_op("mulh ones",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 0, 32'hFFFF_FFFE, 0, 33);
    do_op("mul ones",     2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 0, 32'h0000_0001, 0, 33);
    do_op("div 100/7",    2'b10, 32'd100,      32'd7,        0, -1, 0, 32'h0000_000E, 0, 33);
    do_op("rem 100/7",    2'b11, 32'd100,      32'd7,        0, -1, 0, 32'h0000_0002, 0, 33);
    do_op("div 5/9",      2'b10, 32'd5,        32'd9,        0, -1, 0, 32'h0000_0000, 0, 33);
    do_op("rem 5/9",      2'b11, 32'd5,        32'd9,        0, -1, 0, 32'h0000_0005, 0, 33);
    do_op("div by zero",  2'b10, 32'h1234,     32'd0,        0, -1, 0, 32'hFFFF_FFFF, 1, 1);
    do_op("rem by zero",  2'b11, 32'h1234,     32'd0,        0, -1, 0, 32'hFFFF_FFFF, 1, 1);
    do_op("start+abort",  2'b00, 32'h12345,    32'h10,       1, -1, 0, 32'h0012_3450, 0, 33);
    do_op("div big",      2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 0, -1, 0, 32'h0000_0001, 0, 33);
    do_op("rem big",      2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 0, -1, 0, 32'h7FFF_FFFE, 0, 33);
    do_op("mulh 2^31x6",  2'b01, 32'h8000_0000, 32'd6,       0, -1, 0, 32'h0000_0003, 0, 33);
    do_op("start in calc", 2'b00, 32'd1000,    32'd1000,     0, 10, 1, 32'h000F_4240, 0, 33);

    // Abort in the tenth CALC cycle: back to idle, no done, previous result kept.
    start = 1'b1; op = 2'b10; a_in = 32'd100; b_in = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort result", result, 32'h000F_4240);
    dn = 0;
    repeat (40) begin @(posedge clk); #1; dn += int'(done); end
    check("abort no done", dn, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort in idle busy", busy, 0);

    // Asynchronous reset in CALC cycle 20, then an immediate start on the first edge after release.
    start = 1'b1; op = 2'b00; a_in = 32'hFFFF; b_in = 32'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    check("pre-reset busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset busy", busy, 0);
    check("async reset result", result, 0);
    check("async reset done", done, 0);
    check("async reset alu_a", alu_a, 0);
    check("async reset alu_ac", alu_ac, AC_ADD);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op("mul 3x3 after reset", 2'b00, 32'd3, 32'd3, 0, -1, 0, 32'h0000_0009, 0, 33);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
